// File: rtl/bin2bcd_if.sv
// Handshake bundle for bin2bcd_seq: input operand channel and BCD result channel.
// The converter uses the slave modport; the producer/consumer side uses master.
interface bin2bcd_if #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic                  sign;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, overflow, sign
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, overflow, sign
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional feature macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign reported.
module bin2bcd_seq #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    bin2bcd_if.slave     bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_digits;
    logic               r_ovf_acc;
    logic               r_sign_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;
    logic               r_sign;

    logic [BCD_W-1:0]   w_adj;
    logic [TOT_W-1:0]   w_cat;
    logic [TOT_W-1:0]   w_shl;
    logic               w_carry;
    logic [BIN_W-1:0]   w_load;
    logic               w_sign_in;

`ifdef BIN2BCD_SIGNED_EN
    // Magnitude is taken as BIN_W-bit unsigned so the most negative value stays exact.
    assign w_sign_in = bus.bin[BIN_W-1];
    assign w_load    = w_sign_in ? (~bus.bin + BIN_W'(1)) : bus.bin;
`else
    assign w_sign_in = 1'b0;
    assign w_load    = bus.bin;
`endif

    // Add-3 correction applied to every digit in parallel before the shift.
    always_comb begin
        w_adj = r_digits;
        for (int k = 0; k < DIGITS; k++) begin
            w_adj[4*k +: 4] = dd_adjust(r_digits[4*k +: 4]);
        end
    end

    assign w_cat   = {w_adj, r_shift};
    assign w_carry = w_cat[TOT_W-1];
    assign w_shl   = {w_cat[TOT_W-2:0], 1'b0};

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_digits    <= '0;
            r_ovf_acc   <= 1'b0;
            r_sign_acc  <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bcd       <= '0;
            r_overflow  <= 1'b0;
            r_sign      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_shift    <= w_load;
                        r_digits   <= '0;
                        r_ovf_acc  <= 1'b0;
                        r_sign_acc <= w_sign_in;
                        r_count    <= CNT_W'(BIN_W);
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift   <= w_shl[BIN_W-1:0];
                    r_digits  <= w_shl[TOT_W-1:BIN_W];
                    r_ovf_acc <= r_ovf_acc | w_carry;
                    r_count   <= r_count - CNT_W'(1);
                    // Last bit: publish the freshly shifted digits, not the stale registers.
                    if (r_count == CNT_W'(1)) begin
                        r_bcd       <= w_shl[TOT_W-1:BIN_W];
                        r_overflow  <= r_ovf_acc | w_carry;
                        r_sign      <= r_sign_acc;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bcd       = r_bcd;
    assign bus.overflow  = r_overflow;
    assign bus.sign      = r_sign;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised and directed bench for bin2bcd_seq; two instances (7-bit/3-digit and 8-bit) share clk/rst.
module tb_bin2bcd_seq;
`ifdef BIN2BCD_SIGNED_EN
    localparam int D_B = 3;
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam int D_B = 2;
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bin2bcd_if #(.BIN_W(7), .DIGITS(3))   if_a ();
    bin2bcd_if #(.BIN_W(8), .DIGITS(D_B)) if_b ();

    bin2bcd_seq #(.BIN_W(7), .DIGITS(3))   dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(D_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the operand's value.
    function automatic longint ref_mag(input logic [31:0] v, input int w);
        longint u = longint'(v) & ((64'sd1 <<< w) - 64'sd1);
        if (SIGNED_MODE && v[w-1]) return (64'sd1 <<< w) - u;
        return u;
    endfunction

    function automatic logic [31:0] ref_bcd(input longint mag, input int digits);
        logic [31:0] r = '0;
        longint m = mag;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint mag, input int digits);
        longint lim = 1;
        for (int k = 0; k < digits; k++) lim = lim * 10;
        return mag >= lim;
    endfunction

    task automatic set_in(input int sel, input logic vld, input logic [31:0] v);
        if (sel == 1) begin if_b.in_valid = vld; if_b.bin = v[7:0]; end
        else          begin if_a.in_valid = vld; if_a.bin = v[6:0]; end
    endtask

    task automatic set_rdy(input int sel, input logic r);
        if (sel == 1) if_b.out_ready = r; else if_a.out_ready = r;
    endtask

    function automatic logic [31:0] rd(input int sel, input int what);
        case (what)
            0: return (sel == 1) ? 32'(if_b.in_ready)  : 32'(if_a.in_ready);
            1: return (sel == 1) ? 32'(if_b.out_valid) : 32'(if_a.out_valid);
            2: return (sel == 1) ? 32'(if_b.bcd)       : 32'(if_a.bcd);
            3: return (sel == 1) ? 32'(if_b.overflow)  : 32'(if_a.overflow);
            default: return (sel == 1) ? 32'(if_b.sign) : 32'(if_a.sign);
        endcase
    endfunction

    // One full transaction with a fixed latency check and optional backpressure hold.
    task automatic convert(input int sel, input logic [31:0] v, input int hold);
        int w = (sel == 1) ? 8 : 7;
        int d = (sel == 1) ? D_B : 3;
        longint mag = ref_mag(v, w);
        logic [31:0] exp_bcd = ref_bcd(mag, d);
        logic exp_ovf = ref_ovf(mag, d);
        logic exp_sign = SIGNED_MODE ? v[w-1] : 1'b0;
        @(negedge clk);
        check_eq("idle_ready", rd(sel, 0), 32'd1);
        set_in(sel, 1'b1, v);
        @(posedge clk); #1;
        set_in(sel, 1'b0, 32'd0);
        check_eq("busy_ready", rd(sel, 0), 32'd0);
        for (int i = 1; i <= w; i++) begin
            @(posedge clk); #1;
            if (i == w - 1) check_eq("early_valid", rd(sel, 1), 32'd0);
        end
        check_eq("latency_valid", rd(sel, 1), 32'd1);
        check_eq("bcd", rd(sel, 2), exp_bcd);
        check_eq("overflow", rd(sel, 3), 32'(exp_ovf));
        check_eq("sign", rd(sel, 4), 32'(exp_sign));
        for (int i = 0; i < hold; i++) begin
            set_in(sel, 1'b1, $urandom);
            @(posedge clk); #1;
            check_eq("hold_valid", rd(sel, 1), 32'd1);
            check_eq("hold_bcd", rd(sel, 2), exp_bcd);
            check_eq("hold_ready", rd(sel, 0), 32'd0);
        end
        set_in(sel, 1'b0, 32'd0);
        set_rdy(sel, 1'b1);
        @(posedge clk); #1;
        set_rdy(sel, 1'b0);
        check_eq("drain_valid", rd(sel, 1), 32'd0);
        check_eq("drain_ready", rd(sel, 0), 32'd1);
        check_eq("kept_bcd", rd(sel, 2), exp_bcd);
        check_eq("kept_ovf", rd(sel, 3), 32'(exp_ovf));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        set_in(0, 1'b0, 32'd0); set_in(1, 1'b0, 32'd0);
        set_rdy(0, 1'b0); set_rdy(1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_ready", rd(s, 0), 32'd1);
            check_eq("rst_valid", rd(s, 1), 32'd0);
            check_eq("rst_bcd", rd(s, 2), 32'd0);
            check_eq("rst_ovf", rd(s, 3), 32'd0);
            check_eq("rst_sign", rd(s, 4), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        convert(0, 32'd127, 0);
        convert(0, 32'd0, 0);
        convert(0, 32'd99, 0);
        convert(1, 32'd255, 0);
        convert(1, 32'd42, 0);
        convert(1, 32'h9C, 0);
        convert(1, 32'h80, 0);
        convert(0, 32'd64, 5);

        // Reset in the middle of a conversion must abort it.
        @(negedge clk);
        set_in(0, 1'b1, 32'd100);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", rd(0, 0), 32'd1);
        check_eq("mid_rst_valid", rd(0, 1), 32'd0);
        check_eq("mid_rst_bcd", rd(0, 2), 32'd0);
        check_eq("mid_rst_ovf", rd(0, 3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        convert(0, 32'd77, 0);

        for (int n = 0; n < 24; n++) begin
            convert(0, $urandom_range(127, 0), $urandom_range(2, 0));
            convert(1, $urandom_range(255, 0), $urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
